bcp_driver: RTL and testbench
=============================

BCP_DRIVER -- requirements
Module: bcp_driver

Interface
REQ-001 The block SHALL expose: clk  in  1  system clock, rising-edge active.
REQ-002 The block SHALL expose: rst  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL expose: start  in  1  one-cycle request to begin a propagation run; ignored unless busy=0.
REQ-004 The block SHALL expose: clause_in  in  12  clause word, sampled on start; [7:4] literal-present mask, [3:0] literal polarity (1 = positive).
REQ-005 The block SHALL expose: dec_free, dec_assign  in  4 each  free and assignment vectors, sampled on start.
REQ-006 The block SHALL expose: initial_data  out  12  clause word driven to the checker.
REQ-007 The block SHALL expose: bcp_initial  out  1  clause-load strobe to the checker.
REQ-008 The block SHALL expose: en  out  1  evaluate strobe to the checker.
REQ-009 The block SHALL expose: free, assignment  out  4 each  working vectors driven to the checker.
REQ-010 The block SHALL expose: unit_exist, flag  in  1 each; encoded_implication  in  2  checker response (unit found; conflict; implied variable index).
REQ-011 The block SHALL expose: busy, done, conflict  out  1 each  run status; implied_cnt  out  3  implications applied in the current run.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, ARM, EVAL, WAIT, APPLY, FIN.
REQ-013 IDLE -> LOAD on start; same edge registers clause_in, dec_free, dec_assign; clears done, conflict, implied_cnt.
REQ-014 LOAD: bcp_initial=1 for exactly one cycle with initial_data = registered clause; -> ARM.
REQ-015 ARM: one idle cycle, bcp_initial=0, en=0; -> EVAL.
REQ-016 EVAL: en=1 for exactly one cycle; 3-bit wait counter cleared; -> WAIT.
REQ-017 WAIT: response sampled each cycle for at most 4 cycles after EVAL; flag=1 has priority over unit_exist.
REQ-018 WAIT, flag=1: conflict=1, -> FIN.
REQ-019 WAIT, unit_exist=1: k = encoded_implication registered, -> APPLY.
REQ-020 WAIT, 4 cycles without response: -> FIN with conflict=0.
REQ-021 APPLY, free[k]=1: free[k]<=0, assignment[k]<=clause[k] (polarity bit), implied_cnt+1, -> EVAL (re-evaluation).
REQ-022 APPLY, free[k]=0 (stale implication): vectors unchanged, -> FIN.
REQ-023 APPLY, free becomes 4'b0000 after the update: -> FIN instead of EVAL.
REQ-024 FIN: done=1 for one cycle, -> IDLE; conflict, free, assignment, implied_cnt held until next start.
REQ-025 busy SHALL be 1 in every state except IDLE; start while busy=1 SHALL be ignored.
REQ-026 implied_cnt SHALL saturate at 4; it cannot exceed free-bit count, no wrap.
REQ-027 bcp_initial and en SHALL never be 1 in the same cycle; each SHALL be registered (glitch-free).

Reset
REQ-028 rst=0 SHALL immediately force IDLE, bcp_initial=0, en=0, busy=0, done=0, conflict=0, implied_cnt=0, free=4'b1111, assignment=4'b0000, initial_data=0.
REQ-029 rst asserted mid-run SHALL abandon the run with no done pulse; first start after release behaves as from power-up.

Verification
REQ-030 Reset: rst=0 during EVAL -> outputs at REQ-028 values same cycle, no done.
REQ-031 Single unit: start, clause=12'b01_10_1110_0110, dec_free=4'b0100, dec_assign=4'b1000; checker answers unit_exist=1, idx=2 two cycles after en, then silence -> free=4'b0000, assignment=4'b1100, implied_cnt=1, done, conflict=0.
REQ-032 Conflict: flag=1 and unit_exist=1 same cycle after first en -> conflict=1, free/assignment unchanged, implied_cnt=0.
REQ-033 No response: checker silent -> done exactly 4 cycles after en, conflict=0, vectors equal dec_* inputs.
REQ-034 Stale: unit_exist=1, idx=3 with dec_free[3]=0 -> done, vectors unchanged, implied_cnt=0.
REQ-035 Chain: dec_free=4'b1111, checker returns idx 0,1,2,3 in turn -> four en pulses, free=0, implied_cnt=4, start during run ignored.

Source files
------------

// File: rtl/bcp_driver.sv
// bcp_driver: sequences one Boolean-constraint-propagation run against an
// external clause checker. It loads a clause, strobes an evaluation, and waits
// a bounded time for a checker response. Each accepted unit implication is
// applied to the working free/assignment vectors, and the clause is evaluated
// again until a conflict, a timeout, a stale implication or no free variables
// remain.
//
// Handshake: start is a single-cycle request. It is accepted only on a cycle
// where busy=0 and is ignored otherwise. bcp_initial and en are single-cycle
// registered strobes to the checker. The checker response (flag, unit_exist,
// encoded_implication) is sampled only while waiting, in the three cycles
// that follow the en cycle. flag takes priority over unit_exist. If neither
// is seen by the third cycle, done rises in the fourth cycle after en.
module bcp_driver (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] clause_in,
    input  logic [3:0]  dec_free,
    input  logic [3:0]  dec_assign,
    output logic [11:0] initial_data,
    output logic        bcp_initial,
    output logic        en,
    output logic [3:0]  free,
    output logic [3:0]  assignment,
    input  logic        unit_exist,
    input  logic        flag,
    input  logic [1:0]  encoded_implication,
    output logic        busy,
    output logic        done,
    output logic        conflict,
    output logic [2:0]  implied_cnt,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_APPLY = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [11:0] clause_q;
    logic [3:0]  polarity;
    logic [2:0]  wait_cnt;
    logic [1:0]  imp_idx;
    logic [3:0]  free_upd;

    assign polarity     = clause_q[3:0];
    assign free_upd     = free & ~(4'b0001 << imp_idx);
    assign initial_data = clause_q;
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

    // Next-state selection for the propagation sequence.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_ARM;
            S_ARM:   state_nx = S_EVAL;
            S_EVAL:  state_nx = S_WAIT;
            S_WAIT: begin
                if (flag)
                    state_nx = S_FIN;
                else if (unit_exist)
                    state_nx = S_APPLY;
                else if (wait_cnt == 3'd2)
                    state_nx = S_FIN;
            end
            // Re-evaluate only if the implication was applied and some
            // variable is still free.
            S_APPLY: begin
                if (free[imp_idx] && (free_upd != 4'b0000))
                    state_nx = S_EVAL;
                else
                    state_nx = S_FIN;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Checker strobes and done are decoded from the next state so that they
    // come straight out of flops and line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcp_initial <= 1'b0;
            en          <= 1'b0;
            done        <= 1'b0;
        end else begin
            bcp_initial <= (state_nx == S_LOAD);
            en          <= (state_nx == S_EVAL);
            done        <= (state_nx == S_FIN);
        end
    end

    // Run datapath: capture on start, count the wait window, and apply
    // implications to the working vectors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clause_q    <= 12'd0;
            free        <= 4'b1111;
            assignment  <= 4'b0000;
            conflict    <= 1'b0;
            implied_cnt <= 3'd0;
            wait_cnt    <= 3'd0;
            imp_idx     <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        clause_q    <= clause_in;
                        free        <= dec_free;
                        assignment  <= dec_assign;
                        conflict    <= 1'b0;
                        implied_cnt <= 3'd0;
                    end
                end
                S_EVAL: wait_cnt <= 3'd0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (flag)
                        conflict <= 1'b1;
                    else if (unit_exist)
                        imp_idx <= encoded_implication;
                end
                // A stale implication (variable already assigned) leaves the
                // vectors untouched.
                S_APPLY: begin
                    if (free[imp_idx]) begin
                        free                <= free_upd;
                        assignment[imp_idx] <= polarity[imp_idx];
                        if (implied_cnt != 3'd4)
                            implied_cnt <= implied_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcp_driver.sv
// Bench for bcp_driver. The bench plays the part of the clause checker from a
// per-evaluation response script. A run-level model predicts the outcome:
// final vectors, count, conflict, number of evaluations and the done cycle.
module tb_bcp_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] clause_in = 12'd0;
    logic [3:0]  dec_free = 4'd0;
    logic [3:0]  dec_assign = 4'd0;
    logic [11:0] initial_data;
    logic        bcp_initial;
    logic        en;
    logic [3:0]  free;
    logic [3:0]  assignment;
    logic        unit_exist = 1'b0;
    logic        flag = 1'b0;
    logic [1:0]  encoded_implication = 2'd0;
    logic        busy;
    logic        done;
    logic        conflict;
    logic [2:0]  implied_cnt;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // Response script, one entry per evaluation.
    // kind: 0 silent, 1 unit, 2 conflict, 3 conflict+unit.
    // dly: cycles after en (1..3).
    logic [1:0] r_kind [4];
    logic [1:0] r_idx  [4];
    int         r_dly  [4];

    bcp_driver dut (
        .clk(clk), .rst(rst), .start(start), .clause_in(clause_in),
        .dec_free(dec_free), .dec_assign(dec_assign),
        .initial_data(initial_data), .bcp_initial(bcp_initial), .en(en),
        .free(free), .assignment(assignment), .unit_exist(unit_exist),
        .flag(flag), .encoded_implication(encoded_implication), .busy(busy),
        .done(done), .conflict(conflict), .implied_cnt(implied_cnt),
        .state_dbg(state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 16'(state_dbg), 16'd0);
        check({tag, "_strobes"}, {12'd0, bcp_initial, en, busy, done}, 16'd0);
        check({tag, "_conflict"}, 16'(conflict), 16'd0);
        check({tag, "_cnt"}, 16'(implied_cnt), 16'd0);
        check({tag, "_free"}, 16'(free), 16'hf);
        check({tag, "_assign"}, 16'(assignment), 16'h0);
        check({tag, "_idata"}, 16'(initial_data), 16'h0);
    endtask

    task automatic set_silent();
        for (int i = 0; i < 4; i++) begin
            r_kind[i] = 2'd0;
            r_idx[i]  = 2'd0;
            r_dly[i]  = 1;
        end
    endtask

    task automatic set_resp(input int n, input logic [1:0] kind, input logic [1:0] idx, input int dly);
        r_kind[n] = kind;
        r_idx[n]  = idx;
        r_dly[n]  = dly;
    endtask

    // One propagation run: model prediction, then cycle-accurate checker play.
    task automatic run_txn(input string tag, input logic [11:0] cl, input logic [3:0] df,
                           input logic [3:0] da, input bit inject);
        logic [3:0] m_free;
        logic [3:0] m_asg;
        int  m_cnt, m_ens, m_fin, ev;
        bit  m_conf, stop;
        int  n_en, bi_cnt, ov_cnt, resp_c, resp_n, done_c;

        // Run-level model. Cycle 0 is the load cycle and the first en is in
        // cycle 2. The checker answers dly cycles after en. An applied
        // implication re-evaluates two cycles after the answer. A silent
        // checker ends the run four cycles after en.
        m_free = df; m_asg = da; m_cnt = 0; m_ens = 0; m_conf = 1'b0;
        ev = 2; stop = 1'b0; m_fin = 0;
        while (!stop) begin
            m_ens++;
            if (m_ens > 4 || r_kind[m_ens-1] == 2'd0) begin
                m_fin = ev + 4; stop = 1'b1;
            end else if (r_kind[m_ens-1][1]) begin
                m_conf = 1'b1; m_fin = ev + r_dly[m_ens-1] + 1; stop = 1'b1;
            end else if (!m_free[r_idx[m_ens-1]]) begin
                m_fin = ev + r_dly[m_ens-1] + 2; stop = 1'b1;
            end else begin
                m_free[r_idx[m_ens-1]] = 1'b0;
                m_asg[r_idx[m_ens-1]]  = cl[r_idx[m_ens-1]];
                m_cnt++;
                if (m_free == 4'b0000) begin
                    m_fin = ev + r_dly[m_ens-1] + 2; stop = 1'b1;
                end else begin
                    ev = ev + r_dly[m_ens-1] + 2;
                end
            end
        end

        n_en = 0; bi_cnt = 0; ov_cnt = 0; resp_c = -1; resp_n = 0; done_c = -1;
        @(negedge clk);
        start = 1'b1; clause_in = cl; dec_free = df; dec_assign = da;
        for (int c = 0; c < 80 && done_c < 0; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (inject && c == 3) begin
                start = 1'b1;
                clause_in = 12'($urandom);
                dec_free = 4'($urandom);
                dec_assign = 4'($urandom);
            end
            if (inject && c == 4) start = 1'b0;
            if (bcp_initial) begin
                bi_cnt++;
                check({tag, "_load_cycle"}, 16'(c), 16'd0);
                check({tag, "_idata"}, 16'(initial_data), 16'(cl));
            end
            if (bcp_initial && en) ov_cnt++;
            if (en) begin
                if (n_en < 4 && r_kind[n_en] != 2'd0) begin
                    resp_c = c + r_dly[n_en];
                    resp_n = n_en;
                end
                n_en++;
            end
            if (c == resp_c) begin
                unit_exist = r_kind[resp_n][0];
                flag = r_kind[resp_n][1];
                encoded_implication = r_idx[resp_n];
            end else begin
                unit_exist = 1'b0; flag = 1'b0; encoded_implication = 2'd0;
            end
            if (done) done_c = c;
        end
        unit_exist = 1'b0; flag = 1'b0; encoded_implication = 2'd0;

        check({tag, "_done_seen"}, 16'(done_c >= 0), 16'd1);
        check({tag, "_done_cycle"}, 16'(done_c), 16'(m_fin));
        check({tag, "_en_pulses"}, 16'(n_en), 16'(m_ens));
        check({tag, "_load_pulses"}, 16'(bi_cnt), 16'd1);
        check({tag, "_strobe_overlap"}, 16'(ov_cnt), 16'd0);
        check({tag, "_free"}, 16'(free), 16'(m_free));
        check({tag, "_assign"}, 16'(assignment), 16'(m_asg));
        check({tag, "_cnt"}, 16'(implied_cnt), 16'(m_cnt));
        check({tag, "_conflict"}, 16'(conflict), 16'(m_conf));
        @(negedge clk);
        check({tag, "_post_done_busy"}, {14'd0, done, busy}, 16'd0);
        check({tag, "_held_free"}, 16'(free), 16'(m_free));
    endtask

    initial begin
        bit any_done;

        // Power-up reset.
        set_silent();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b1;
        @(negedge clk);

        // Reset asserted during the evaluate cycle abandons the run.
        start = 1'b1; clause_in = 12'h5a5; dec_free = 4'b1010; dec_assign = 4'b0101;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_en_before_reset", 16'(en), 16'd1);
        rst = 1'b0;
        #1;
        check_reset_values("mid");
        any_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("mid_no_done", 16'(any_done), 16'd0);

        // Single unit implication.
        set_silent();
        set_resp(0, 2'd1, 2'd2, 2);
        run_txn("single", 12'b0110_1110_0110, 4'b0100, 4'b1000, 1'b0);

        // Conflict with simultaneous unit response.
        set_silent();
        set_resp(0, 2'd3, 2'd1, 1);
        run_txn("conflict", 12'h0f3, 4'b0110, 4'b1001, 1'b0);

        // Silent checker.
        set_silent();
        run_txn("silent", 12'h0c5, 4'b1011, 4'b0100, 1'b0);

        // Stale implication.
        set_silent();
        set_resp(0, 2'd1, 2'd3, 3);
        run_txn("stale", 12'h0ff, 4'b0111, 4'b1000, 1'b0);

        // Chain of four implications with a start request mid-run.
        set_silent();
        for (int i = 0; i < 4; i++) set_resp(i, 2'd1, 2'(i), int'($urandom_range(1, 3)));
        run_txn("chain", 12'h0a9, 4'b1111, 4'b0000, 1'b1);

        // Randomized runs.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                set_resp(i, (sel < 6) ? 2'd1 : (sel < 8) ? 2'd0 : 2'($urandom_range(2, 3)),
                         2'($urandom), int'($urandom_range(1, 3)));
            end
            run_txn("rand", 12'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
